// File: rtl/t03_sram_arbiter.sv
// Shares a 1W/1R SRAM macro between instruction fetch and data memory.
// Maps byte addresses to words, sequences macro timing, and does RMW for partial stores.
module t03_sram_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_sel,
  output logic [31:0]           d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic                  busy,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [31:0]           sram_dout1
);

  localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RMW_ISSUE, RMW_WAIT, RMW_WR, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  gnt_i_q, gnt_i_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            sel_q, sel_d;

  logic                  i_ack_d, i_err_d, d_ack_d, d_err_d, busy_d, csb0_d, csb1_d;
  logic [31:0]           i_rdata_d, d_rdata_d, din0_d, merged;
  logic [ADDR_WIDTH-1:0] addr0_d, addr1_d;

  logic [31:0] i_offs, d_offs;
  logic        i_bad, d_bad, d_req, d_wins;

  assign i_offs = i_addr - BASE_ADDR;
  assign d_offs = d_addr - BASE_ADDR;
  assign i_bad  = (i_addr[1:0] != 2'b00) || ({1'b0, i_offs} >= SPAN);
  assign d_bad  = (d_addr[1:0] != 2'b00) || ({1'b0, d_offs} >= SPAN) || (d_ren && d_wen);
  assign d_req  = d_ren | d_wen;
  // Data has priority until fetch has watched MAX_D_STREAK data grants in a row.
  assign d_wins = d_req && !(i_req && (streak_q == STREAK_MAX));

  always_comb begin
    merged = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      merged[8*b +: 8] = sel_q[b] ? wdata_q[8*b +: 8] : sram_dout1[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    gnt_i_d   = gnt_i_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    csb0_d    = 1'b1;
    csb1_d    = 1'b1;
    addr0_d   = sram_addr0;
    addr1_d   = sram_addr1;
    din0_d    = sram_din0;

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          gnt_i_d  = 1'b0;
          word_d   = d_offs[ADDR_WIDTH+1:2];
          wdata_d  = d_wdata;
          sel_d    = d_sel;
          streak_d = (i_req && streak_q != STREAK_MAX) ? streak_q + 1'b1 :
                     (i_req ? streak_q : '0);
          if (d_bad) begin
            state_d   = DONE;
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else if (d_ren) begin
            state_d = RD_ISSUE;
            csb1_d  = 1'b0;
            addr1_d = d_offs[ADDR_WIDTH+1:2];
          end else if (d_sel == 4'hF) begin
            state_d = WR_ISSUE;
            csb0_d  = 1'b0;
            addr0_d = d_offs[ADDR_WIDTH+1:2];
            din0_d  = d_wdata;
          end else if (d_sel == 4'h0) begin
            state_d = DONE;
            d_ack_d = 1'b1;
          end else begin
            state_d = RMW_ISSUE;
            csb1_d  = 1'b0;
            addr1_d = d_offs[ADDR_WIDTH+1:2];
          end
        end else if (i_req) begin
          gnt_i_d  = 1'b1;
          streak_d = '0;
          word_d   = i_offs[ADDR_WIDTH+1:2];
          if (i_bad) begin
            state_d   = DONE;
            i_ack_d   = 1'b1;
            i_err_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            state_d = RD_ISSUE;
            csb1_d  = 1'b0;
            addr1_d = i_offs[ADDR_WIDTH+1:2];
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d = DONE;
        if (gnt_i_q) begin
          i_rdata_d = sram_dout1;
          i_ack_d   = 1'b1;
        end else begin
          d_rdata_d = sram_dout1;
          d_ack_d   = 1'b1;
        end
      end
      WR_ISSUE: begin
        state_d = DONE;
        d_ack_d = 1'b1;
      end
      RMW_ISSUE: state_d = RMW_WAIT;
      RMW_WAIT: begin
        state_d = RMW_WR;
        csb0_d  = 1'b0;
        addr0_d = word_q;
        din0_d  = merged;
      end
      RMW_WR: begin
        state_d = DONE;
        d_ack_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      gnt_i_q    <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      i_rdata    <= '0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      busy       <= 1'b0;
      sram_csb0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      gnt_i_q    <= gnt_i_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      i_rdata    <= i_rdata_d;
      i_ack      <= i_ack_d;
      i_err      <= i_err_d;
      d_rdata    <= d_rdata_d;
      d_ack      <= d_ack_d;
      d_err      <= d_err_d;
      busy       <= busy_d;
      sram_csb0  <= csb0_d;
      sram_addr0 <= addr0_d;
      sram_din0  <= din0_d;
      sram_csb1  <= csb1_d;
      sram_addr1 <= addr1_d;
    end
  end

endmodule

// File: tb/tb_t03_sram_arbiter.sv
// Self-checking bench for t03_sram_arbiter: behavioural SRAM macro plus a
// transaction-level reference model (word memory, latency table, arbitration rule).
module tb_t03_sram_arbiter;
  localparam int unsigned AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst;
  logic          i_req;
  logic [31:0]   i_addr, i_rdata;
  logic          i_ack, i_err;
  logic          d_ren, d_wen;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic [3:0]    d_sel;
  logic          d_ack, d_err, busy;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [31:0]   sram_din0, sram_dout1;

  t03_sram_arbiter #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .busy(busy),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural macro: ports registered on posedge, read data valid after negedge,
  // garbage on dout1 right after every posedge.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr_q;
  logic          rd_pend = 1'b0;
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  always @(posedge clk) begin
    if (!sram_csb0) begin
      mem[sram_addr0] <= sram_din0;
      wr_cnt <= wr_cnt + 1;
    end
    rd_pend <= !sram_csb1;
    if (!sram_csb1) begin
      rd_addr_q <= sram_addr1;
      rd_cnt <= rd_cnt + 1;
    end
    sram_dout1 <= $urandom;
  end

  always @(negedge clk) if (rd_pend) sram_dout1 <= mem[rd_addr_q];

  always @(negedge clk) if (n_rst) check("csb_excl", 32'(sram_csb0 | sram_csb1), 32'd1);

  // Reference model state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          ref_streak = 0;

  function automatic logic addr_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'(4 << AW));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[AW+1:2]);
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    w = 32'($urandom_range(0, 31));
    if (k == 0) return (w << 2) | 32'($urandom_range(1, 3));
    if (k == 1) return BASE + 32'h1000 + (w << 2);
    return BASE + (w << 2);
  endfunction

  task automatic wait_ack(output int lat, output logic si, output logic sd);
    logic done;
    done = 1'b0; lat = 0; si = 1'b0; sd = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        done = 1'b1; si = i_ack; sd = d_ack;
      end else lat++;
    end
    if (!done) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic data_txn(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
    logic err_x, si, sd, got_err;
    int lat_x, rd_x, wr_x, w, lat, rd0, wr0;
    logic [31:0] got_rdata;
    w = word_of(addr);
    err_x = addr_bad(addr) || (ren && wen);
    if (err_x)             begin lat_x = 0; rd_x = 0; wr_x = 0; end
    else if (ren)          begin lat_x = 2; rd_x = 1; wr_x = 0; end
    else if (sel == 4'hF)  begin lat_x = 1; rd_x = 0; wr_x = 1; end
    else if (sel == 4'h0)  begin lat_x = 0; rd_x = 0; wr_x = 0; end
    else                   begin lat_x = 3; rd_x = 1; wr_x = 1; end
    @(negedge clk);
    d_ren = ren; d_wen = wen; d_addr = addr; d_wdata = wdata; d_sel = sel;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    wait_ack(lat, si, sd);
    got_rdata = d_rdata; got_err = d_err;
    d_ren = 1'b0; d_wen = 1'b0;
    @(negedge clk);
    check("d_ack", 32'(sd), 32'd1);
    check("i_ack_quiet", 32'(si), 32'd0);
    check("d_latency", 32'(lat), 32'(lat_x));
    check("d_err", 32'(got_err), 32'(err_x));
    if (err_x) check("d_rdata_err", got_rdata, 32'd0);
    else if (ren) check("d_rdata", got_rdata, ref_mem[w]);
    check("sram_reads", 32'(rd_cnt - rd0), 32'(rd_x));
    check("sram_writes", 32'(wr_cnt - wr0), 32'(wr_x));
    check("busy_after", 32'(busy), 32'd0);
    if (!err_x && wen)
      for (int unsigned b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    ref_streak = 0;
  endtask

  task automatic fetch_txn(input logic [31:0] addr);
    logic err_x, si, sd, got_err;
    int w, lat, rd0, wr0;
    logic [31:0] got_rdata;
    w = word_of(addr);
    err_x = addr_bad(addr);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    wait_ack(lat, si, sd);
    got_rdata = i_rdata; got_err = i_err;
    i_req = 1'b0;
    @(negedge clk);
    check("i_ack", 32'(si), 32'd1);
    check("d_ack_quiet", 32'(sd), 32'd0);
    check("i_latency", 32'(lat), err_x ? 32'd0 : 32'd2);
    check("i_err", 32'(got_err), 32'(err_x));
    check("i_rdata", got_rdata, err_x ? 32'd0 : ref_mem[w]);
    check("i_sram_reads", 32'(rd_cnt - rd0), err_x ? 32'd0 : 32'd1);
    check("i_sram_writes", 32'(wr_cnt - wr0), 32'd0);
    ref_streak = 0;
  endtask

  // Both requesters held high; the model picks the winner for each grant.
  task automatic contention(input int n);
    int g, iw, dw;
    logic exp_f;
    iw = $urandom_range(0, 31);
    dw = $urandom_range(0, 31);
    @(negedge clk);
    i_req = 1'b1; i_addr = BASE + 32'(iw * 4);
    d_ren = 1'b1; d_addr = BASE + 32'(dw * 4);
    g = 0;
    for (int c = 0; c < 400 && g < n; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        exp_f = (ref_streak == MAXS);
        ref_streak = exp_f ? 0 : ref_streak + 1;
        check("arb_fetch", 32'(i_ack), 32'(exp_f));
        check("arb_data", 32'(d_ack), 32'(!exp_f));
        if (exp_f) check("arb_i_rdata", i_rdata, ref_mem[iw]);
        else       check("arb_d_rdata", d_rdata, ref_mem[dw]);
        g++;
        if (g == n) begin i_req = 1'b0; d_ren = 1'b0; end
      end
    end
    if (g < n) begin
      check("arb_timeout", 32'(g), 32'(n));
      i_req = 1'b0; d_ren = 1'b0;
    end
    @(negedge clk);
    ref_streak = 0;
  endtask

  task automatic rmw_reset();
    logic seen;
    int wr0;
    seen = 1'b0;
    @(negedge clk);
    d_wen = 1'b1; d_addr = BASE + 32'h10; d_wdata = $urandom; d_sel = 4'b0011;
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk); seen |= d_ack;
    @(negedge clk); seen |= d_ack;
    n_rst = 1'b0; d_wen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= d_ack; end
    check("rst_rmw_ack", 32'(seen), 32'd0);
    check("rst_rmw_busy", 32'(busy), 32'd0);
    check("rst_rmw_csb0", 32'(sram_csb0), 32'd1);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_rmw_writes", 32'(wr_cnt - wr0), 32'd0);
  endtask

  initial begin
    int lat;
    logic si, sd;
    int r;
    logic [3:0] sel;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    n_rst = 1'b0; i_req = 1'b1; i_addr = BASE + 32'h8;
    d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_csb0", 32'(sram_csb0), 32'd1);
    check("rst_csb1", 32'(sram_csb1), 32'd1);
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    wait_ack(lat, si, sd);
    check("rst_first_latency", 32'(lat), 32'd2);
    check("rst_first_fetch", 32'(si), 32'd1);
    i_req = 1'b0;
    @(negedge clk);

    data_txn(1'b0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    data_txn(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    data_txn(1'b0, 1'b1, BASE + 32'h10, 32'h11223344, 4'hF);
    data_txn(1'b0, 1'b1, BASE + 32'h10, 32'hAABBCCDD, 4'b0101);
    data_txn(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    data_txn(1'b1, 1'b0, BASE + 32'h2, 32'h0, 4'hF);
    data_txn(1'b1, 1'b0, BASE + 32'h1000, 32'h0, 4'hF);
    data_txn(1'b1, 1'b1, BASE + 32'h10, 32'h12345678, 4'hF);
    data_txn(1'b0, 1'b1, BASE + 32'h10, 32'h55555555, 4'h0);
    fetch_txn(BASE + 32'h13);
    fetch_txn(BASE + 32'h10);

    rmw_reset();
    data_txn(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'hF);

    for (int w = 0; w < 32; w++) data_txn(1'b0, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) fetch_txn(rand_addr());
      else begin
        r = $urandom_range(0, 9);
        sel = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        data_txn(r < 5, (r == 0) || (r >= 5), rand_addr(), $urandom, sel);
      end
    end

    contention(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/t03_sram_arbiter.md
Name: t03_sram_arbiter

Overview:
Single-clock controller that shares the 32x1024 dual-port SRAM macro (one write port, one read port) between the instruction-fetch requester and the data-memory requester of the team CPU. It maps 32-bit byte addresses to word indices and sequences the macro's register-then-negedge timing. It performs read-modify-write for partial-byte stores and returns a one-cycle ack with registered read data. It sits between the CPU memory interface and the SRAM instance; the SRAM's clk0 and clk1 are both tied to clk.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address mapped to SRAM word 0
ADDR_WIDTH, 10, SRAM word-address width (depth 1<<ADDR_WIDTH)
MAX_D_STREAK, 4, consecutive data grants allowed while fetch is waiting

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  synchronous active-low reset
i_req  in  1  fetch read request, level, held until i_ack
i_addr  in  32  fetch byte address
i_rdata  out  32  fetch read data, valid while i_ack=1
i_ack  out  1  fetch done, one-cycle pulse
i_err  out  1  fetch error, qualified by i_ack
d_ren  in  1  data read request, level, held until d_ack
d_wen  in  1  data write request, level, held until d_ack
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_sel  in  4  byte enables; bit n selects d_wdata[8n+7:8n]
d_rdata  out  32  load data, valid while d_ack=1
d_ack  out  1  data done, one-cycle pulse
d_err  out  1  data error, qualified by d_ack
busy  out  1  high whenever state is not IDLE
sram_csb0  out  1  SRAM write-port chip select, active low
sram_addr0  out  ADDR_WIDTH  SRAM write word address
sram_din0  out  32  SRAM write data
sram_csb1  out  1  SRAM read-port chip select, active low
sram_addr1  out  ADDR_WIDTH  SRAM read word address
sram_dout1  in  32  SRAM read data

Behaviour:
- All outputs registered. Reset values: csb0=csb1=1, sram addrs/din=0, i_rdata=d_rdata=0, acks/errs=0, busy=0, state=IDLE, streak=0.
- Reset asserted at any edge returns to IDLE with reset values. A write whose csb0 was already sampled by the SRAM may still complete; no abort is guaranteed.
- Word index = (addr - BASE_ADDR)[ADDR_WIDTH+1:2].
- Error condition: addr[1:0]!=0, or (addr - BASE_ADDR) >= 4<<ADDR_WIDTH, or d_ren&d_wen both high.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RMW_ISSUE, RMW_WAIT, RMW_WR, DONE.
- Requests are sampled only in IDLE. DONE always goes to IDLE, so a request still high during its ack cycle is not re-accepted.
- Arbitration in IDLE: if a data request and i_req are both pending, data wins unless streak==MAX_D_STREAK, in which case fetch wins.
  - streak increments on each data grant while i_req=1.
  - streak clears on a fetch grant, or on a data grant while i_req=0.
  - streak saturates at MAX_D_STREAK.
- Accept at edge E0:
  - Error: go to DONE; ack=1 and err=1 in cycle E0..E1; rdata=0; no SRAM access.
  - Read: RD_ISSUE (csb1=0, addr1=word) -> E1 RD_WAIT (csb1=1) -> E2 rdata<=sram_dout1, DONE, ack=1. Latency 2.
  - Full write (d_sel=4'hF): WR_ISSUE (csb0=0, addr0, din0=d_wdata) -> E1 DONE, ack=1. Latency 1.
  - d_sel=4'h0 write: DONE directly, ack=1, err=0, no SRAM access.
  - Partial write: RMW_ISSUE/RMW_WAIT as for read -> E2 merge (selected bytes from d_wdata, the rest from sram_dout1), RMW_WR (csb0=0) -> E3 DONE, ack=1. Latency 3.
- sram_dout1 is guaranteed valid only at the capture edge, because the macro drives X shortly after each posedge. It is registered there and never used combinationally.
- Reads ignore d_sel. Only the granted requester's ack/rdata/err change; the other holds 0 ack/err.
- csb0 and csb1 are never low in the same cycle.

Test Plan:
- Reset: hold n_rst=0 for 3 cycles with i_req=1 -> csb0=csb1=1, acks=0, busy=0; first accept occurs at the first edge after release.
- Write then read: d_wen, addr 0x10, d_wdata=0xDEADBEEF, d_sel=F -> d_ack one cycle after accept; then d_ren addr 0x10 -> d_ack two cycles after accept with d_rdata=0xDEADBEEF.
- RMW: mem word 4=0x11223344, write d_sel=4'b0101, d_wdata=0xAABBCCDD -> readback 0x11BB33DD; ack three cycles after accept.
- Contention: i_req and d_ren held continuously -> grant pattern is 4 data grants, 1 fetch, repeating; fetch is never starved.
- Errors: d_addr=0x2 -> d_ack=1, d_err=1, d_rdata=0 in the cycle after accept, csb untouched. d_addr=BASE+0x1000 -> same response. d_ren&d_wen both high -> same response.
- Reset mid-RMW (n_rst=0 in RMW_WAIT) -> IDLE, no d_ack, csb0 never asserted.
